// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
//   state_e        : top-level game state encoding
//   KEY_*          : keycodes with special meaning
//   HS_*           : bit index of each hurt source in request/grant vectors
//   hurt_arbitrate : fixed-priority one-hot hurt arbiter (elec > proj > contact)
package game_pkg;

  localparam int unsigned TIMER_W   = 8;
  localparam int unsigned TIMER_MAX = 255;
  localparam int unsigned LIVES_W   = 4;
  localparam int unsigned LIVES_MAX = 15;
  localparam int unsigned KEY_W     = 8;
  localparam int unsigned HURT_W    = 3;
  localparam int unsigned HEALTH_W  = 10;

  localparam logic [KEY_W-1:0] KEY_NONE       = 8'h00;
  localparam logic [KEY_W-1:0] KEY_PAUSE_DFLT = 8'h13;

  localparam int unsigned HS_CONTACT = 0;
  localparam int unsigned HS_ELEC    = 1;
  localparam int unsigned HS_PROJ    = 2;

  typedef enum logic [2:0] {
    ST_MENU   = 3'd0,
    ST_INTRO  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  // One-hot grant for the highest-priority active request.
  function automatic logic [HURT_W-1:0] hurt_arbitrate(input logic [HURT_W-1:0] req);
    logic [HURT_W-1:0] grant;
    grant = '0;
    if (req[HS_ELEC]) begin
      grant[HS_ELEC] = 1'b1;
    end else if (req[HS_PROJ]) begin
      grant[HS_PROJ] = 1'b1;
    end else if (req[HS_CONTACT]) begin
      grant[HS_CONTACT] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable 8-bit down-counter that saturates at zero.
//   clk, rst  : frame clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this frame (wins over en)
//   load_val  : value to load
//   en        : decrement by one this frame when nonzero
//   zero      : registered flag, high while the count is zero
module frame_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               zero_q, zero_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - TIMER_W'(1);
    end
    zero_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer (MENU -> INTRO -> PLAY <-> PAUSED -> OVER) and hurt arbiter.
// Clocked once per video frame.
//   frame_clk, Reset     : frame clock, synchronous active-high reset
//   keycode              : current keyboard code, 0 = no key
//   hurt_contact/elec/proj : level hurt requests from the three sources
//   boss_health          : boss remaining health; 0 ends the game as a win
//   state, menu, intro_active, play_en, game_over : state and its decodes
//   player_win           : result of the last game, held until a new game starts
//   player_lives         : remaining lives
//   player_hurt          : high while the invulnerability window is open
//   hurt_grant           : one-frame one-hot grant {proj, elec, contact}
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned      LIVES_INIT       = 5,
  parameter int unsigned      INTRO_FRAMES     = 120,
  parameter int unsigned      INVULN_FRAMES    = 80,
  parameter int unsigned      OVER_HOLD_FRAMES = 180,
  parameter logic [KEY_W-1:0] KEY_PAUSE        = KEY_PAUSE_DFLT
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [KEY_W-1:0]    keycode,
  input  logic                hurt_contact,
  input  logic                hurt_elec,
  input  logic                hurt_proj,
  input  logic [HEALTH_W-1:0] boss_health,
  output state_e              state,
  output logic                menu,
  output logic                intro_active,
  output logic                play_en,
  output logic                game_over,
  output logic                player_win,
  output logic [LIVES_W-1:0]  player_lives,
  output logic                player_hurt,
  output logic [HURT_W-1:0]   hurt_grant
);

  // Reject timer loads that do not fit the 8-bit counters.
  if (INTRO_FRAMES < 1 || INTRO_FRAMES > TIMER_MAX ||
      OVER_HOLD_FRAMES < 1 || OVER_HOLD_FRAMES > TIMER_MAX ||
      INVULN_FRAMES > TIMER_MAX || LIVES_INIT > LIVES_MAX) begin : g_param_check
    $error("game_flow_ctrl: parameter out of range");
  end

  localparam logic [TIMER_W-1:0] INTRO_LOAD  = TIMER_W'(INTRO_FRAMES - 1);
  localparam logic [TIMER_W-1:0] INVULN_LOAD = TIMER_W'(INVULN_FRAMES);
  localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(OVER_HOLD_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD  = LIVES_W'(LIVES_INIT);

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_prev_q, key_prev_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                win_q, win_d;
  logic [HURT_W-1:0]   grant_q, grant_d;
  logic                menu_q, menu_d;
  logic                intro_q, intro_d;
  logic                play_q, play_d;
  logic                over_q, over_d;

  logic                intro_load, intro_en, intro_zero;
  logic                inv_load, inv_en, inv_zero;
  logic                hold_load, hold_en, hold_zero;
  logic [TIMER_W-1:0]  inv_val;

  logic                key_press, pause_press;
  logic [HURT_W-1:0]   hurt_req;

  // A held key counts once: only a change to a nonzero code is a press.
  assign key_press   = (keycode != KEY_NONE) && (keycode != key_prev_q);
  assign pause_press = key_press && (keycode == KEY_PAUSE);
  assign hurt_req    = {hurt_proj, hurt_elec, hurt_contact};

  frame_timer u_intro_timer (
    .clk      (frame_clk),
    .rst      (Reset),
    .load     (intro_load),
    .load_val (INTRO_LOAD),
    .en       (intro_en),
    .zero     (intro_zero)
  );

  frame_timer u_inv_timer (
    .clk      (frame_clk),
    .rst      (Reset),
    .load     (inv_load),
    .load_val (inv_val),
    .en       (inv_en),
    .zero     (inv_zero)
  );

  frame_timer u_hold_timer (
    .clk      (frame_clk),
    .rst      (Reset),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .en       (hold_en),
    .zero     (hold_zero)
  );

  // Next state, life count, grant and timer controls.
  always_comb begin
    state_d    = state_q;
    key_prev_d = keycode;
    lives_d    = lives_q;
    win_d      = win_q;
    grant_d    = '0;
    intro_load = 1'b0;
    intro_en   = 1'b0;
    inv_load   = 1'b0;
    inv_val    = '0;
    inv_en     = 1'b0;
    hold_load  = 1'b0;
    hold_en    = 1'b0;

    unique case (state_q)
      ST_MENU: begin
        if (key_press) begin
          state_d    = ST_INTRO;
          intro_load = 1'b1;
          lives_d    = LIVES_LOAD;
          win_d      = 1'b0;
        end
      end

      ST_INTRO: begin
        if (intro_zero) begin
          state_d = ST_PLAY;
        end else begin
          intro_en = 1'b1;
        end
      end

      ST_PLAY: begin
        inv_en = 1'b1;
        // Boss defeat beats pause, pause beats a hit.
        if (boss_health == '0) begin
          state_d   = ST_OVER;
          win_d     = 1'b1;
          hold_load = 1'b1;
          inv_load  = 1'b1;
        end else if (pause_press) begin
          state_d = ST_PAUSED;
        end else if (inv_zero && (hurt_req != '0)) begin
          grant_d = hurt_arbitrate(hurt_req);
          if (lives_q != '0) begin
            lives_d = lives_q - LIVES_W'(1);
          end
          // Last life lost: end the game with the window closed.
          if (lives_q <= LIVES_W'(1)) begin
            state_d   = ST_OVER;
            win_d     = 1'b0;
            hold_load = 1'b1;
            inv_load  = 1'b1;
          end else begin
            inv_load = 1'b1;
            inv_val  = INVULN_LOAD;
          end
        end
      end

      ST_PAUSED: begin
        if (pause_press) begin
          state_d = ST_PLAY;
        end
      end

      ST_OVER: begin
        hold_en = 1'b1;
        if (hold_zero && key_press) begin
          state_d = ST_MENU;
        end
      end

      default: begin
        state_d = ST_MENU;
      end
    endcase

    menu_d  = (state_d == ST_MENU);
    intro_d = (state_d == ST_INTRO);
    play_d  = (state_d == ST_PLAY);
    over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q    <= ST_MENU;
      key_prev_q <= KEY_NONE;
      lives_q    <= LIVES_LOAD;
      win_q      <= 1'b0;
      grant_q    <= '0;
      menu_q     <= 1'b1;
      intro_q    <= 1'b0;
      play_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_prev_d;
      lives_q    <= lives_d;
      win_q      <= win_d;
      grant_q    <= grant_d;
      menu_q     <= menu_d;
      intro_q    <= intro_d;
      play_q     <= play_d;
      over_q     <= over_d;
    end
  end

  assign state        = state_q;
  assign menu         = menu_q;
  assign intro_active = intro_q;
  assign play_en      = play_q;
  assign game_over    = over_q;
  assign player_win   = win_q;
  assign player_lives = lives_q;
  assign hurt_grant   = grant_q;
  // Straight off the invulnerability timer's zero flop.
  assign player_hurt  = ~inv_zero;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a frame-level reference model pushes the
// expected output word for every driven frame; it is popped and compared after
// the DUT clocks. Directed checks cover the timing boundaries.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int unsigned LIVES_INIT       = 5;
  localparam int unsigned INTRO_FRAMES     = 120;
  localparam int unsigned INVULN_FRAMES    = 80;
  localparam int unsigned OVER_HOLD_FRAMES = 180;
  localparam logic [7:0]  KP               = 8'h13;
  localparam logic [9:0]  BOSS_OK          = 10'd500;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic        hurt_contact, hurt_elec, hurt_proj;
  logic [9:0]  boss_health;
  state_e      state;
  logic        menu, intro_active, play_en, game_over, player_win, player_hurt;
  logic [3:0]  player_lives;
  logic [2:0]  hurt_grant;

  game_flow_ctrl #(
    .LIVES_INIT       (LIVES_INIT),
    .INTRO_FRAMES     (INTRO_FRAMES),
    .INVULN_FRAMES    (INVULN_FRAMES),
    .OVER_HOLD_FRAMES (OVER_HOLD_FRAMES),
    .KEY_PAUSE        (KP)
  ) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .hurt_contact (hurt_contact),
    .hurt_elec    (hurt_elec),
    .hurt_proj    (hurt_proj),
    .boss_health  (boss_health),
    .state        (state),
    .menu         (menu),
    .intro_active (intro_active),
    .play_en      (play_en),
    .game_over    (game_over),
    .player_win   (player_win),
    .player_lives (player_lives),
    .player_hurt  (player_hurt),
    .hurt_grant   (hurt_grant)
  );

  always #5 frame_clk = ~frame_clk;

  int n_vec = 0;
  int n_bad = 0;
  int frame_no = 0;

  // Reference model state
  state_e     m_state = ST_MENU;
  int         m_lives = 0;
  bit         m_win = 1'b0;
  logic [2:0] m_grant = 3'b000;
  int         m_tint = 0;
  int         m_tinv = 0;
  int         m_thold = 0;
  logic [7:0] m_kprev = 8'h00;

  logic [15:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @frame %0d: got 0x%0h, expected 0x%0h", tag, frame_no, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {state, menu, intro_active, play_en, game_over, player_win,
            player_lives, player_hurt, hurt_grant};
  endfunction

  function automatic logic [15:0] model_vec();
    return {m_state, (m_state == ST_MENU), (m_state == ST_INTRO), (m_state == ST_PLAY),
            (m_state == ST_OVER), m_win, 4'(m_lives), (m_tinv != 0), m_grant};
  endfunction

  task automatic model_step(input logic rst, input logic [7:0] key,
                            input logic [2:0] req, input logic [9:0] boss);
    bit press, hurt_ok;
    m_grant = 3'b000;
    if (rst) begin
      m_state = ST_MENU; m_lives = LIVES_INIT; m_win = 1'b0;
      m_tint = 0; m_tinv = 0; m_thold = 0; m_kprev = 8'h00;
      return;
    end
    press   = (key != 8'h00) && (key != m_kprev);
    m_kprev = key;
    case (m_state)
      ST_MENU: if (press) begin
        m_state = ST_INTRO; m_tint = INTRO_FRAMES - 1; m_lives = LIVES_INIT; m_win = 1'b0;
      end
      ST_INTRO: begin
        if (m_tint == 0) m_state = ST_PLAY;
        else m_tint--;
      end
      ST_PLAY: begin
        hurt_ok = (m_tinv == 0);
        if (m_tinv > 0) m_tinv--;
        if (boss == 10'd0) begin
          m_state = ST_OVER; m_win = 1'b1; m_tinv = 0; m_thold = OVER_HOLD_FRAMES - 1;
        end else if (press && key == KP) begin
          m_state = ST_PAUSED;
        end else if (hurt_ok && req != 3'b000) begin
          if (req[1])      m_grant = 3'b010;
          else if (req[2]) m_grant = 3'b100;
          else             m_grant = 3'b001;
          if (m_lives > 0) m_lives--;
          if (m_lives == 0) begin
            m_state = ST_OVER; m_win = 1'b0; m_tinv = 0; m_thold = OVER_HOLD_FRAMES - 1;
          end else begin
            m_tinv = INVULN_FRAMES;
          end
        end
      end
      ST_PAUSED: if (press && key == KP) m_state = ST_PLAY;
      ST_OVER: begin
        if (m_thold == 0) begin
          if (press) m_state = ST_MENU;
        end else begin
          m_thold--;
        end
      end
      default: m_state = ST_MENU;
    endcase
  endtask

  // Drive one frame, predict it, clock it, then compare against the oldest prediction.
  task automatic step(input logic rst, input logic [7:0] key,
                      input logic [2:0] req, input logic [9:0] boss);
    logic [15:0] exp;
    Reset = rst;
    keycode = key;
    {hurt_proj, hurt_elec, hurt_contact} = req;
    boss_health = boss;
    model_step(rst, key, req, boss);
    exp_q.push_back(model_vec());
    @(posedge frame_clk);
    #1;
    frame_no++;
    exp = exp_q.pop_front();
    check_eq("frame", 32'(dut_vec()), 32'(exp));
  endtask

  task automatic run_until(input state_e target, input int budget, output int n);
    n = 0;
    while (state != target && n < budget) begin
      step(1'b0, 8'h00, 3'b000, BOSS_OK);
      n++;
    end
    check_eq("reach_state", 32'(state), 32'(target));
  endtask

  initial begin
    int n, entries, f_intro, g, hurt_cnt, left_early;
    state_e prev_st;
    logic [2:0] grant_or;

    // Reset
    step(1'b1, 8'h00, 3'b000, BOSS_OK);
    step(1'b1, 8'h00, 3'b000, BOSS_OK);
    check_eq("rst_state", 32'(state), 32'(ST_MENU));
    check_eq("rst_menu", 32'(menu), 32'd1);
    check_eq("rst_lives", 32'(player_lives), 32'd5);
    check_eq("rst_grant", 32'(hurt_grant), 32'd0);

    // Held key gives one MENU->INTRO; INTRO lasts 120 frames
    entries = 0; f_intro = 0; prev_st = state;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h04, 3'b000, BOSS_OK);
      if (state == ST_INTRO && prev_st == ST_MENU) begin
        entries++;
        f_intro = frame_no;
      end
      prev_st = state;
    end
    check_eq("intro_entries", 32'(entries), 32'd1);
    run_until(ST_PLAY, 300, n);
    check_eq("intro_len", 32'(frame_no - f_intro), 32'(INTRO_FRAMES));
    check_eq("play_en", 32'(play_en), 32'd1);

    // Elec beats contact; contact held regains a grant once the window closes
    step(1'b0, 8'h00, 3'b011, BOSS_OK);
    check_eq("grant_elec", 32'(hurt_grant), 32'b010);
    check_eq("lives_4", 32'(player_lives), 32'd4);
    g = frame_no; hurt_cnt = 1; n = 0;
    do begin
      step(1'b0, 8'h00, 3'b001, BOSS_OK);
      n++;
      if (player_hurt && hurt_grant == 3'b000) hurt_cnt++;
    end while (hurt_grant == 3'b000 && n < 300);
    check_eq("regrant_gap", 32'(frame_no - g), 32'(INVULN_FRAMES + 1));
    check_eq("hurt_len", 32'(hurt_cnt), 32'(INVULN_FRAMES));
    check_eq("grant_contact", 32'(hurt_grant), 32'b001);
    check_eq("lives_3", 32'(player_lives), 32'd3);

    // Pause with 40 frames of invulnerability left
    n = 0;
    while (m_tinv != 40 && n < 100) begin
      step(1'b0, 8'h00, 3'b000, BOSS_OK);
      n++;
    end
    step(1'b0, KP, 3'b111, BOSS_OK);
    check_eq("pause_state", 32'(state), 32'(ST_PAUSED));
    check_eq("pause_nogrant", 32'(hurt_grant), 32'd0);
    grant_or = 3'b000;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, KP, 3'b111, BOSS_OK);
      grant_or |= hurt_grant;
    end
    check_eq("paused_grants", 32'(grant_or), 32'd0);
    check_eq("paused_hurt", 32'(player_hurt), 32'd1);
    step(1'b0, 8'h00, 3'b000, BOSS_OK);
    step(1'b0, KP, 3'b000, BOSS_OK);
    check_eq("resume_state", 32'(state), 32'(ST_PLAY));
    // The pausing frame was still a PLAY frame, so 39 frames remain.
    n = 0;
    while (player_hurt && n < 100) begin
      step(1'b0, 8'h00, 3'b000, BOSS_OK);
      n++;
    end
    check_eq("resume_left", 32'(n), 32'd39);

    // Drain lives to 1, then a projectile hit ends the game
    n = 0;
    while (player_lives != 4'd1 && n < 400) begin
      step(1'b0, 8'h00, 3'b001, BOSS_OK);
      n++;
    end
    check_eq("lives_1", 32'(player_lives), 32'd1);
    n = 0;
    while (player_hurt && n < 100) begin
      step(1'b0, 8'h00, 3'b000, BOSS_OK);
      n++;
    end
    step(1'b0, 8'h00, 3'b100, BOSS_OK);
    check_eq("grant_proj", 32'(hurt_grant), 32'b100);
    check_eq("lives_0", 32'(player_lives), 32'd0);
    check_eq("over_lose", 32'(game_over), 32'd1);
    check_eq("win_0", 32'(player_win), 32'd0);
    check_eq("over_hurt_clr", 32'(player_hurt), 32'd0);

    // Presses during the hold are ignored; the first one after it returns to MENU
    left_early = 0;
    for (int i = 1; i < int'(OVER_HOLD_FRAMES); i++) begin
      step(1'b0, (i % 2) ? 8'h05 : 8'h00, 3'b000, BOSS_OK);
      if (state != ST_OVER) left_early++;
    end
    check_eq("over_hold", 32'(left_early), 32'd0);
    step(1'b0, 8'h07, 3'b000, BOSS_OK);
    check_eq("over_exit", 32'(state), 32'(ST_MENU));

    // Boss defeat beats a same-frame contact hit
    step(1'b0, 8'h04, 3'b000, BOSS_OK);
    check_eq("new_game_lives", 32'(player_lives), 32'd5);
    run_until(ST_PLAY, 300, n);
    step(1'b0, 8'h00, 3'b001, 10'd0);
    check_eq("boss_over", 32'(state), 32'(ST_OVER));
    check_eq("boss_win", 32'(player_win), 32'd1);
    check_eq("boss_nogrant", 32'(hurt_grant), 32'd0);
    check_eq("boss_lives", 32'(player_lives), 32'd5);
    for (int i = 1; i < int'(OVER_HOLD_FRAMES); i++) step(1'b0, 8'h00, 3'b000, 10'd0);
    step(1'b0, 8'h04, 3'b000, 10'd0);
    check_eq("win_held_menu", 32'(player_win), 32'd1);
    step(1'b0, 8'h00, 3'b000, BOSS_OK);
    step(1'b0, 8'h09, 3'b000, BOSS_OK);
    check_eq("win_cleared", 32'(player_win), 32'd0);

    // Reset in the middle of INTRO
    for (int i = 0; i < 50; i++) step(1'b0, 8'h00, 3'b000, BOSS_OK);
    step(1'b1, 8'h00, 3'b000, BOSS_OK);
    check_eq("rst_intro_state", 32'(state), 32'(ST_MENU));
    check_eq("rst_intro_active", 32'(intro_active), 32'd0);

    // Reset in the middle of PAUSED with the window open
    step(1'b0, 8'h04, 3'b000, BOSS_OK);
    run_until(ST_PLAY, 300, n);
    step(1'b0, 8'h00, 3'b001, BOSS_OK);
    step(1'b0, KP, 3'b000, BOSS_OK);
    check_eq("pre_rst_paused", 32'(state), 32'(ST_PAUSED));
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 3'b000, BOSS_OK);
    step(1'b1, 8'h00, 3'b000, BOSS_OK);
    check_eq("rst_pause_state", 32'(state), 32'(ST_MENU));
    check_eq("rst_pause_lives", 32'(player_lives), 32'd5);
    check_eq("rst_pause_hurt", 32'(player_hurt), 32'd0);
    check_eq("rst_pause_grant", 32'(hurt_grant), 32'd0);
    step(1'b0, 8'h00, 3'b000, BOSS_OK);
    step(1'b0, 8'h04, 3'b000, BOSS_OK);
    run_until(ST_PLAY, 300, n);
    check_eq("intro_after_rst", 32'(n), 32'(INTRO_FRAMES));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog @frame %0d: got timeout, expected completion", frame_no);
    $fatal(1, "watchdog expired");
  end

endmodule
